// File: rtl/sat_pkg.sv
// Shared definitions for the SAT decision datapath.
//
// Contents:
//   VALUE_W                  width of a variable value code {implied, val[1:0]}
//   VAL_FREE/FALSE/TRUE      two-bit polarity codes
//   dec_state_e              decision controller FSM states
//   decision_code()          builds the full value code for a fresh decision
package sat_pkg;

    localparam int unsigned VALUE_W = 3;

    localparam logic [1:0] VAL_FREE  = 2'b00;
    localparam logic [1:0] VAL_FALSE = 2'b01;
    localparam logic [1:0] VAL_TRUE  = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDone
    } dec_state_e;

    // Decisions are never implied, so bit 2 is always clear.
    function automatic logic [VALUE_W-1:0] decision_code(input logic phase);
        return {1'b0, (phase ? VAL_TRUE : VAL_FALSE)};
    endfunction

endpackage

// File: rtl/onehot_pri_enc.sv
// Lowest-set-bit priority encoder.
//
// Converts a multi-hot candidate vector into the binary index of its
// lowest-numbered set bit.
//
// Ports:
//   onehot_i  [NUM_VARS-1:0]   candidate vector
//   idx_o     [WIDTH_VAR-1:0]  index of the lowest set bit (0 when none set)
//   found_o                    at least one bit of onehot_i is set
module onehot_pri_enc #(
    parameter int unsigned NUM_VARS  = 8,
    parameter int unsigned WIDTH_VAR = $clog2(NUM_VARS)
) (
    input  logic [NUM_VARS-1:0]  onehot_i,
    output logic [WIDTH_VAR-1:0] idx_o,
    output logic                 found_o
);

    // Scan from the top down so the last hit, i.e. the lowest bit, wins.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_VARS - 1; i >= 0; i--) begin
            if (onehot_i[i]) begin
                idx_o = WIDTH_VAR'(i);
            end
        end
    end

    assign found_o = |onehot_i;

endmodule

// File: rtl/decide_var_ctrl.sv
// Decision variable controller.
//
// Picks the lowest-numbered free variable from index_i on a start request,
// offers it to the state list with the next decision level, and holds the
// offer until acknowledged. Reports "all variables assigned" when no
// candidate exists and flags a sticky error if the level would overflow.
//
// Optional feature: define DECIDE_PHASE_SAVE_EN to keep a saved polarity per
// variable (written through the phase_* port); the decision then uses the
// saved polarity. Without it every decision is "false" and phase_* is unused.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start_decide_i   request a decision (sampled in idle only)
//   index_i          free-variable candidate vector
//   level_i          current decision level
//   ack_i            state list accepted the offered assignment
//   phase_upd_i      saved-phase write strobe
//   phase_var_i      variable whose saved phase is written
//   phase_val_i      polarity written (1 = true)
//   valid_o          assignment offered
//   var_o            decided variable
//   value_o          value code {implied, val[1:0]}
//   level_o          new decision level
//   done_decide_o    decision finished (one-cycle pulse)
//   all_assigned_o   no free variable (one-cycle pulse)
//   err_lvl_o        decision level overflow (sticky until reset)
module decide_var_ctrl
    import sat_pkg::*;
#(
    parameter int unsigned NUM_VARS  = 8,
    parameter int unsigned WIDTH_VAR = $clog2(NUM_VARS),
    parameter int unsigned WIDTH_LVL = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_decide_i,
    input  logic [NUM_VARS-1:0]  index_i,
    input  logic [WIDTH_LVL-1:0] level_i,
    input  logic                 ack_i,
    input  logic                 phase_upd_i,
    input  logic [WIDTH_VAR-1:0] phase_var_i,
    input  logic                 phase_val_i,
    output logic                 valid_o,
    output logic [WIDTH_VAR-1:0] var_o,
    output logic [VALUE_W-1:0]   value_o,
    output logic [WIDTH_LVL-1:0] level_o,
    output logic                 done_decide_o,
    output logic                 all_assigned_o,
    output logic                 err_lvl_o
);

    localparam logic [WIDTH_LVL-1:0] LvlMax = '1;
    localparam logic [WIDTH_LVL-1:0] LvlOne = WIDTH_LVL'(1);

    dec_state_e             state_q;
    logic                   valid_q;
    logic [WIDTH_VAR-1:0]   var_q;
    logic [VALUE_W-1:0]     value_q;
    logic [WIDTH_LVL-1:0]   level_q;
    logic                   done_q;
    logic                   all_asg_q;
    logic                   err_q;

    logic [WIDTH_VAR-1:0]   cand_idx;
    logic                   cand_found;
    logic                   phase_sel;

    onehot_pri_enc #(
        .NUM_VARS  (NUM_VARS),
        .WIDTH_VAR (WIDTH_VAR)
    ) u_pri_enc (
        .onehot_i (index_i),
        .idx_o    (cand_idx),
        .found_o  (cand_found)
    );

`ifdef DECIDE_PHASE_SAVE_EN
    logic [NUM_VARS-1:0] phase_q;

    // A write in the same cycle as a capture lands after the edge, so the
    // capture naturally sees the old bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else if (phase_upd_i && (32'(phase_var_i) < NUM_VARS)) begin
            phase_q[phase_var_i] <= phase_val_i;
        end
    end

    assign phase_sel = phase_q[cand_idx];
`else
    logic unused_phase;
    assign unused_phase = ^{phase_upd_i, phase_var_i, phase_val_i};
    assign phase_sel    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            valid_q   <= 1'b0;
            var_q     <= '0;
            value_q   <= '0;
            level_q   <= '0;
            done_q    <= 1'b0;
            all_asg_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            all_asg_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_decide_i) begin
                        if (level_i == LvlMax) begin
                            // No room for another level: refuse the decision.
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else if (!cand_found) begin
                            all_asg_q <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            var_q   <= cand_idx;
                            level_q <= level_i + LvlOne;
                            value_q <= decision_code(phase_sel);
                            valid_q <= 1'b1;
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (ack_i) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // done_q is high for exactly this cycle.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign valid_o        = valid_q;
    assign var_o          = var_q;
    assign value_o        = value_q;
    assign level_o        = level_q;
    assign done_decide_o  = done_q;
    assign all_assigned_o = all_asg_q;
    assign err_lvl_o      = err_q;

endmodule
